// File: rtl/dram_wb_guard.sv
// Guard between the Wishbone interconnect and the LiteDRAM user port.
// One transaction in flight; requests are registered before reaching DRAM;
// requests error out until calibration succeeds; a watchdog converts a hung
// DRAM access into a Wishbone error and counts such aborts.
module dram_wb_guard #(
  parameter int ADR_W   = 28,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init_done,
  input  logic             init_error,
  input  logic [ADR_W-1:0] s_wb_adr,
  input  logic [31:0]      s_wb_dat_w,
  output logic [31:0]      s_wb_dat_r,
  input  logic [3:0]       s_wb_sel,
  input  logic             s_wb_we,
  input  logic             s_wb_cyc,
  input  logic             s_wb_stb,
  output logic             s_wb_stall,
  output logic             s_wb_ack,
  output logic             s_wb_err,
  output logic [ADR_W-1:0] m_wb_adr,
  output logic [31:0]      m_wb_dat_w,
  output logic [3:0]       m_wb_sel,
  output logic             m_wb_we,
  output logic             m_wb_cyc,
  output logic             m_wb_stb,
  input  logic [31:0]      m_wb_dat_r,
  input  logic             m_wb_stall,
  input  logic             m_wb_ack,
  input  logic             m_wb_err,
  output logic [7:0]       timeout_cnt
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  // Watchdog terminal value; TIMEOUT is limited to 16 bits.
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [15:0]      wd_q, wd_d;
  logic [7:0]       tcnt_q, tcnt_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic [31:0]      dat_r_q, dat_r_d;
  logic [ADR_W-1:0] adr_q, adr_d;
  logic [31:0]      dat_w_q, dat_w_d;
  logic [3:0]       sel_q, sel_d;
  logic             we_q, we_d;
  logic             mcyc_q, mcyc_d;
  logic             mstb_q, mstb_d;
  logic             ready;
  logic             accept;

  assign ready  = init_done & ~init_error;
  assign accept = s_wb_cyc & s_wb_stb & (state_q == IDLE);

  // Next-state, request latch, response capture and watchdog decisions.
  // In flight, an abandoned cycle beats a DRAM response, which beats expiry.
  always_comb begin
    state_d = state_q;
    wd_d    = wd_q;
    tcnt_d  = tcnt_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    dat_r_d = dat_r_q;
    adr_d   = adr_q;
    dat_w_d = dat_w_q;
    sel_d   = sel_q;
    we_d    = we_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          adr_d   = s_wb_adr;
          dat_w_d = s_wb_dat_w;
          sel_d   = s_wb_sel;
          we_d    = s_wb_we;
          if (ready) begin
            state_d = ISSUE;
            wd_d    = '0;
          end else begin
            state_d = RESP;
            err_d   = 1'b1;
          end
        end
      end
      ISSUE, WAIT: begin
        wd_d = wd_q + 16'd1;
        if (!s_wb_cyc) begin
          state_d = IDLE;
        end else if (m_wb_ack || m_wb_err) begin
          dat_r_d = m_wb_dat_r;
          ack_d   = m_wb_ack;
          err_d   = ~m_wb_ack;
          state_d = RESP;
        end else if (wd_q == WD_LAST) begin
          err_d   = 1'b1;
          state_d = RESP;
          if (tcnt_q != 8'hFF) tcnt_d = tcnt_q + 8'd1;
        end else if (state_q == ISSUE && !m_wb_stall) begin
          state_d = WAIT;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    mcyc_d = (state_d == ISSUE) || (state_d == WAIT);
    mstb_d = (state_d == ISSUE);
  end

  // State and registered outputs; reset clears every output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wd_q    <= '0;
      tcnt_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_r_q <= '0;
      adr_q   <= '0;
      dat_w_q <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      mcyc_q  <= 1'b0;
      mstb_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      tcnt_q  <= tcnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dat_r_q <= dat_r_d;
      adr_q   <= adr_d;
      dat_w_q <= dat_w_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      mcyc_q  <= mcyc_d;
      mstb_q  <= mstb_d;
    end
  end

  assign s_wb_stall  = (state_q != IDLE);
  assign s_wb_ack    = ack_q;
  assign s_wb_err    = err_q;
  assign s_wb_dat_r  = dat_r_q;
  assign m_wb_adr    = adr_q;
  assign m_wb_dat_w  = dat_w_q;
  assign m_wb_sel    = sel_q;
  assign m_wb_we     = we_q;
  assign m_wb_cyc    = mcyc_q;
  assign m_wb_stb    = mstb_q;
  assign timeout_cnt = tcnt_q;

endmodule

// File: tb/tb_dram_wb_guard.sv
// Bench for dram_wb_guard: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a transaction
// model of the guard.
module tb_dram_wb_guard;
  localparam int ADR_W = 28;
  localparam int TO    = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             init_done, init_error;
  logic [ADR_W-1:0] s_wb_adr;
  logic [31:0]      s_wb_dat_w, s_wb_dat_r;
  logic [3:0]       s_wb_sel;
  logic             s_wb_we, s_wb_cyc, s_wb_stb;
  logic             s_wb_stall, s_wb_ack, s_wb_err;
  logic [ADR_W-1:0] m_wb_adr;
  logic [31:0]      m_wb_dat_w, m_wb_dat_r;
  logic [3:0]       m_wb_sel;
  logic             m_wb_we, m_wb_cyc, m_wb_stb;
  logic             m_wb_stall, m_wb_ack, m_wb_err;
  logic [7:0]       timeout_cnt;

  always #5 clk = ~clk;

  dram_wb_guard #(.ADR_W(ADR_W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .init_done(init_done), .init_error(init_error),
    .s_wb_adr(s_wb_adr), .s_wb_dat_w(s_wb_dat_w), .s_wb_dat_r(s_wb_dat_r),
    .s_wb_sel(s_wb_sel), .s_wb_we(s_wb_we), .s_wb_cyc(s_wb_cyc),
    .s_wb_stb(s_wb_stb), .s_wb_stall(s_wb_stall), .s_wb_ack(s_wb_ack),
    .s_wb_err(s_wb_err), .m_wb_adr(m_wb_adr), .m_wb_dat_w(m_wb_dat_w),
    .m_wb_sel(m_wb_sel), .m_wb_we(m_wb_we), .m_wb_cyc(m_wb_cyc),
    .m_wb_stb(m_wb_stb), .m_wb_dat_r(m_wb_dat_r), .m_wb_stall(m_wb_stall),
    .m_wb_ack(m_wb_ack), .m_wb_err(m_wb_err), .timeout_cnt(timeout_cnt)
  );

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 0;

  // Transaction model: one owned request, whether DRAM took the strobe,
  // how long it has been outstanding, and a one-cycle pending response.
  bit               md_busy, md_taken, md_rv, md_re, md_we;
  int               md_age, md_tcnt;
  logic [31:0]      md_rdata, md_dat;
  logic [ADR_W-1:0] md_adr;
  logic [3:0]       md_sel;
  logic [109:0]     exp_v, act_v;

  initial begin
    md_busy = 0; md_taken = 0; md_rv = 0; md_re = 0; md_we = 0;
    md_age = 0; md_tcnt = 0; md_rdata = '0; md_dat = '0; md_adr = '0; md_sel = '0;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      exp_v = {md_busy | md_rv, md_rv & ~md_re, md_rv & md_re, md_rdata,
               md_adr, md_dat, md_sel, md_we, md_busy, md_busy & ~md_taken,
               8'(md_tcnt)};
      act_v = {s_wb_stall, s_wb_ack, s_wb_err, s_wb_dat_r, m_wb_adr, m_wb_dat_w,
               m_wb_sel, m_wb_we, m_wb_cyc, m_wb_stb, timeout_cnt};
      n_chk++;
      if (act_v === exp_v) n_pass++;
      else $display("FAIL model_cycle t=%0t got=%h exp=%h", $time, act_v, exp_v);
    end
    if (rst) begin
      md_busy = 0; md_taken = 0; md_rv = 0; md_re = 0; md_age = 0; md_tcnt = 0;
      md_rdata = '0; md_adr = '0; md_dat = '0; md_sel = '0; md_we = 0;
    end else if (md_rv) begin
      md_rv = 0;
    end else if (md_busy) begin
      if (!s_wb_cyc) begin
        md_busy = 0;
      end else if (m_wb_ack || m_wb_err) begin
        md_rdata = m_wb_dat_r; md_rv = 1; md_re = !m_wb_ack; md_busy = 0;
      end else if (md_age == TO - 1) begin
        md_rv = 1; md_re = 1; md_busy = 0;
        if (md_tcnt < 255) md_tcnt++;
      end else begin
        if (!m_wb_stall) md_taken = 1;
        md_age++;
      end
    end else if (s_wb_cyc && s_wb_stb) begin
      md_adr = s_wb_adr; md_dat = s_wb_dat_w; md_sel = s_wb_sel; md_we = s_wb_we;
      if (init_done && !init_error) begin
        md_busy = 1; md_taken = 0; md_age = 0;
      end else begin
        md_rv = 1; md_re = 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", nm, got, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic look();
    @(negedge clk); #1;
  endtask

  task automatic req(input logic [ADR_W-1:0] a, input logic [31:0] d,
                     input logic [3:0] s, input logic w);
    s_wb_cyc = 1; s_wb_stb = 1; s_wb_adr = a; s_wb_dat_w = d; s_wb_sel = s; s_wb_we = w;
  endtask

  initial begin
    rst = 1; init_done = 0; init_error = 0;
    s_wb_adr = '0; s_wb_dat_w = '0; s_wb_sel = '0; s_wb_we = 0; s_wb_cyc = 0; s_wb_stb = 0;
    m_wb_dat_r = '0; m_wb_stall = 0; m_wb_ack = 0; m_wb_err = 0;
    repeat (2) tick();
    chk_en = 1;
    tick(); rst = 0; look();
    chk("rst_stall", 32'(s_wb_stall), 0);
    chk("rst_ack", 32'(s_wb_ack), 0);
    chk("rst_mcyc", 32'(m_wb_cyc), 0);
    chk("rst_tcnt", 32'(timeout_cnt), 0);

    // Not calibrated: error response one cycle after accept, no DRAM activity.
    tick(); req(28'h100, 32'h0, 4'hF, 0); look();
    chk("t1_stall_c0", 32'(s_wb_stall), 0);
    tick(); s_wb_stb = 0; look();
    chk("t1_err", 32'(s_wb_err), 1);
    chk("t1_ack", 32'(s_wb_ack), 0);
    chk("t1_mcyc", 32'(m_wb_cyc), 0);
    tick(); s_wb_cyc = 0; look();
    chk("t1_err_once", 32'(s_wb_err), 0);

    // Write with DRAM ack at cycle 3.
    tick(); init_done = 1; req(28'h40, 32'hDEADBEEF, 4'hF, 1); look();
    tick(); s_wb_stb = 0; look();
    chk("t2_mstb", 32'(m_wb_stb), 1);
    chk("t2_madr", 32'(m_wb_adr), 32'h40);
    chk("t2_mdat", m_wb_dat_w, 32'hDEADBEEF);
    chk("t2_msel", 32'(m_wb_sel), 32'hF);
    chk("t2_mwe", 32'(m_wb_we), 1);
    chk("t2_stall_c1", 32'(s_wb_stall), 1);
    tick(); look();
    chk("t2_mstb_c2", 32'(m_wb_stb), 0);
    chk("t2_mcyc_c2", 32'(m_wb_cyc), 1);
    tick(); m_wb_ack = 1; look();
    chk("t2_ack_c3", 32'(s_wb_ack), 0);
    tick(); m_wb_ack = 0; look();
    chk("t2_ack_c4", 32'(s_wb_ack), 1);
    chk("t2_stall_c4", 32'(s_wb_stall), 1);
    chk("t2_mcyc_c4", 32'(m_wb_cyc), 0);
    tick(); s_wb_cyc = 0; look();
    chk("t2_stall_c5", 32'(s_wb_stall), 0);

    // Read with DRAM stall held, ack together with the release.
    tick(); req(28'h40, 32'h0, 4'hF, 0); m_wb_stall = 1; look();
    for (int i = 1; i <= 3; i++) begin
      tick(); s_wb_stb = 0; look();
      chk("t3_mstb_held", 32'(m_wb_stb), 1);
    end
    tick(); m_wb_stall = 0; m_wb_ack = 1; m_wb_dat_r = 32'hDEADBEEF; look();
    chk("t3_mstb_rel", 32'(m_wb_stb), 1);
    tick(); m_wb_ack = 0; m_wb_dat_r = 32'h0; look();
    chk("t3_ack", 32'(s_wb_ack), 1);
    chk("t3_rdata", s_wb_dat_r, 32'hDEADBEEF);
    tick(); s_wb_cyc = 0; look();
    chk("t3_rdata_hold", s_wb_dat_r, 32'hDEADBEEF);

    // Watchdog expiry: error at cycle 17.
    tick(); req(28'h80, 32'h1, 4'h1, 0); look();
    for (int c = 1; c <= 16; c++) begin
      tick(); s_wb_stb = 0; look();
      chk("t4_no_err", 32'(s_wb_err), 0);
    end
    chk("t4_mcyc_c16", 32'(m_wb_cyc), 1);
    tick(); look();
    chk("t4_err_c17", 32'(s_wb_err), 1);
    chk("t4_mcyc_c17", 32'(m_wb_cyc), 0);
    chk("t4_tcnt", 32'(timeout_cnt), 1);
    tick(); s_wb_cyc = 0;

    // Ack on the expiry cycle wins.
    tick(); req(28'h81, 32'h2, 4'h3, 1); look();
    for (int c = 1; c <= 15; c++) begin tick(); s_wb_stb = 0; end
    tick(); m_wb_ack = 1; m_wb_dat_r = 32'hA5A5_0001; look();
    tick(); m_wb_ack = 0; look();
    chk("t5_ack_expiry", 32'(s_wb_ack), 1);
    chk("t5_err_expiry", 32'(s_wb_err), 0);
    chk("t5_tcnt_same", 32'(timeout_cnt), 1);
    tick(); s_wb_cyc = 0;

    // Abandon in WAIT, then a late DRAM ack.
    tick(); req(28'h82, 32'h3, 4'hF, 0); look();
    tick(); s_wb_stb = 0;
    tick(); s_wb_cyc = 0; look();
    chk("t5b_mcyc_wait", 32'(m_wb_cyc), 1);
    tick(); m_wb_ack = 1; look();
    chk("t5b_mcyc_drop", 32'(m_wb_cyc), 0);
    chk("t5b_no_ack", 32'(s_wb_ack), 0);
    tick(); m_wb_ack = 0; look();
    chk("t5b_late_ack", 32'(s_wb_ack), 0);
    chk("t5b_late_err", 32'(s_wb_err), 0);

    // 299 more timeouts saturate the abort counter.
    for (int r = 0; r < 299; r++) begin
      tick(); req(28'(r), 32'(r), 4'hF, 0);
      repeat (17) begin tick(); s_wb_stb = 0; end
      tick(); s_wb_cyc = 0;
    end
    look();
    chk("t4_tcnt_sat", 32'(timeout_cnt), 255);

    // Calibration failed: every request errors, nothing reaches DRAM.
    init_error = 1;
    for (int r = 0; r < 3; r++) begin
      tick(); req(28'(32'h200 + r), 32'(r), 4'hF, r[0]); look();
      tick(); s_wb_stb = 0; look();
      chk("t6_err", 32'(s_wb_err), 1);
      chk("t6_mcyc", 32'(m_wb_cyc), 0);
      tick(); s_wb_cyc = 0;
    end

    // Reset while waiting on DRAM.
    tick(); init_error = 0; req(28'h55, 32'h12345678, 4'h3, 1); look();
    tick(); s_wb_stb = 0;
    tick(); look();
    chk("t6_in_wait", 32'({m_wb_cyc, m_wb_stb}), 32'b10);
    tick(); rst = 1;
    tick(); rst = 0; s_wb_cyc = 0; look();
    chk("t6_rst_mcyc", 32'(m_wb_cyc), 0);
    chk("t6_rst_madr", 32'(m_wb_adr), 0);
    chk("t6_rst_mdat", m_wb_dat_w, 0);
    chk("t6_rst_stall", 32'(s_wb_stall), 0);
    chk("t6_rst_rdata", s_wb_dat_r, 0);
    chk("t6_rst_tcnt", 32'(timeout_cnt), 0);
    chk("t6_rst_resp", 32'({s_wb_ack, s_wb_err}), 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      tick();
      rst        = ($urandom_range(0, 99) == 0);
      init_done  = ($urandom_range(0, 9) != 0);
      init_error = ($urandom_range(0, 19) == 0);
      s_wb_cyc   = ($urandom_range(0, 9) != 0);
      s_wb_stb   = $urandom_range(0, 1) == 1;
      s_wb_adr   = ADR_W'($urandom);
      s_wb_dat_w = $urandom;
      s_wb_sel   = 4'($urandom);
      s_wb_we    = $urandom_range(0, 1) == 1;
      m_wb_stall = ($urandom_range(0, 9) < 4);
      m_wb_ack   = ($urandom_range(0, 19) < 3);
      m_wb_err   = ($urandom_range(0, 19) < 2);
      m_wb_dat_r = $urandom;
    end
    tick(); rst = 0; look();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
